// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: walks pc through a synchronous instruction memory and
// hands each instruction to the control unit over the run/d_in/done handshake.
module instr_fetch_unit #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int TIMEOUT     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH:0]    prog_len,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   run,
    input  logic                   done,
    output logic [ADDR_WIDTH:0]    pc,
    output logic                   busy,
    output logic                   finished,
    output logic                   error
);

    // Handshake: run stays high for every EXEC cycle; done is only honoured in EXEC,
    // and a done sampled at an edge ends the instruction so run is low the next cycle.
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_EXEC, S_FINISH} state_t;

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [ADDR_WIDTH:0] PC_ONE  = 1;
    localparam logic [CW-1:0]       CNT_MAX = CW'(TIMEOUT - 1);

    state_t              state, state_nxt;
    logic [ADDR_WIDTH:0] len_q;
    logic [CW-1:0]       tcnt;
    logic                last_instr;
    logic                timeout_hit;

    assign last_instr  = (pc + PC_ONE) == len_q;
    assign timeout_hit = (tcnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = (prog_len == '0) ? S_FINISH : S_FETCH;
            S_FETCH:  state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_EXEC;
            S_EXEC: begin
                // done outranks a timeout landing on the same edge
                if (done)             state_nxt = last_instr ? S_FINISH : S_FETCH;
                else if (timeout_hit) state_nxt = S_IDLE;
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= '0;
            len_q <= '0;
            instr <= '0;
            tcnt  <= '0;
            error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc    <= '0;
                        len_q <= prog_len;
                        error <= 1'b0;
                        tcnt  <= '0;
                    end
                end
                S_LOAD: begin
                    instr <= mem_rdata;
                    tcnt  <= '0;
                end
                S_EXEC: begin
                    if (done) begin
                        pc   <= pc + PC_ONE;
                        tcnt <= '0;
                    end else if (timeout_hit) begin
                        error <= 1'b1;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_rd_en = (state == S_FETCH);
    assign mem_addr  = pc[ADDR_WIDTH-1:0];
    assign run       = (state == S_EXEC);
    assign busy      = (state != S_IDLE);
    assign finished  = (state == S_FINISH);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a synchronous memory and a 4-cycle
// control-unit model that answers done in the 4th run cycle.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  prog_len;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic        run;
    logic        done;
    logic [8:0]  pc;
    logic        busy;
    logic        finished;
    logic        error;

    logic [15:0] mem [0:255];
    int          n_vec = 0;
    int          n_err = 0;
    int          run_cnt = 0;
    int          fin_cnt = 0;
    bit          cu_enable = 1'b1;
    logic        model_done = 1'b0;
    logic        inj_done = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .instr(instr), .run(run), .done(done), .pc(pc), .busy(busy),
        .finished(finished), .error(error)
    );

    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    // control unit: done during the 4th consecutive run cycle
    always @(negedge clk) begin
        if (run) run_cnt = run_cnt + 1;
        else     run_cnt = 0;
        model_done = cu_enable && run && (run_cnt == 4);
        if (finished) fin_cnt = fin_cnt + 1;
    end
    assign done = model_done | inj_done;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int len);
        start    = 1'b1;
        prog_len = 9'(len);
        step();
        start    = 1'b0;
    endtask

    // walks a normally terminating program; optional disturbances in FETCH/LOAD
    task automatic run_prog(input int len, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input bit disturb);
        logic [15:0] exp_i [0:2];
        exp_i[0] = e0; exp_i[1] = e1; exp_i[2] = e2;
        do_start(len);
        for (int i = 0; i < len; i++) begin
            check("fetch_rd_en", {31'd0, mem_rd_en}, 32'd1);
            check("fetch_addr", {24'd0, mem_addr}, i);
            check("fetch_run", {31'd0, run}, 32'd0);
            if (disturb) begin
                inj_done = 1'b1; start = 1'b1; prog_len = 9'd0;
            end
            step();
            check("load_run", {31'd0, run}, 32'd0);
            step();
            inj_done = 1'b0; start = 1'b0;
            check("exec_instr", {16'd0, instr}, {16'd0, exp_i[i]});
            for (int j = 0; j < 4; j++) begin
                check("exec_run", {31'd0, run}, 32'd1);
                check("exec_pc", {23'd0, pc}, i);
                step();
            end
        end
        check("fin_pulse", {31'd0, finished}, 32'd1);
        check("fin_run", {31'd0, run}, 32'd0);
        check("fin_pc", {23'd0, pc}, len);
        check("fin_busy", {31'd0, busy}, 32'd1);
        step();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_fin", {31'd0, finished}, 32'd0);
    endtask

    initial begin
        int fin_before;
        for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
        reset = 1'b1; start = 1'b0; prog_len = 9'd0;
        step(); step();
        reset = 1'b0;
        step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_run", {31'd0, run}, 32'd0);
        check("rst_pc", {23'd0, pc}, 32'd0);
        check("rst_instr", {16'd0, instr}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("rst_fin", {31'd0, finished}, 32'd0);

        // single instruction
        mem[0] = 16'h2A04;
        run_prog(1, 16'h2A04, 16'h0000, 16'h0000, 1'b0);

        // three instructions
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        run_prog(3, 16'h1111, 16'h2222, 16'h3333, 1'b0);

        // timeout: done never comes
        cu_enable  = 1'b0;
        fin_before = fin_cnt;
        do_start(2);
        step(); step();
        for (int j = 0; j < 8; j++) begin
            check("to_run", {31'd0, run}, 32'd1);
            check("to_err_low", {31'd0, error}, 32'd0);
            step();
        end
        check("to_run_drop", {31'd0, run}, 32'd0);
        check("to_error", {31'd0, error}, 32'd1);
        check("to_busy", {31'd0, busy}, 32'd0);
        check("to_pc", {23'd0, pc}, 32'd0);
        step(); step();
        check("to_sticky", {31'd0, error}, 32'd1);
        check("to_no_fin", fin_cnt, fin_before);
        cu_enable = 1'b1;
        do_start(1);
        check("to_err_clr", {31'd0, error}, 32'd0);
        step(); step(); step(); step(); step(); step();
        check("to_restart_fin", {31'd0, finished}, 32'd1);
        step();

        // empty program
        do_start(0);
        check("len0_fin", {31'd0, finished}, 32'd1);
        check("len0_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("len0_run", {31'd0, run}, 32'd0);
        step();
        check("len0_idle", {31'd0, busy}, 32'd0);
        check("len0_fin_off", {31'd0, finished}, 32'd0);
        check("len0_rd_en2", {31'd0, mem_rd_en}, 32'd0);

        // reset during the 2nd EXEC cycle
        do_start(4);
        step(); step(); step();
        check("rx_run_hi", {31'd0, run}, 32'd1);
        check("rx_instr", {16'd0, instr}, 32'h1111);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rx_run", {31'd0, run}, 32'd0);
        check("rx_pc", {23'd0, pc}, 32'd0);
        check("rx_instr0", {16'd0, instr}, 32'd0);
        check("rx_busy", {31'd0, busy}, 32'd0);
        step();
        run_prog(1, 16'h1111, 16'h0000, 16'h0000, 1'b0);

        // stray start / done / prog_len changes during FETCH and LOAD
        run_prog(3, 16'h1111, 16'h2222, 16'h3333, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
